rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter POR_CYCLES, default 16'd50000: the number of clk_cog cycles that dig_nres is held low after nres deasserts.
REQ-002 SHALL have parameter REBOOT_CYCLES, default 16'd16: the number of cycles that dig_nres is held low on a software reboot.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16'd1024: the number of cycles to wait after an oscillator or PLL enable turns on before the new clock select is applied.
REQ-004 SHALL have port clk_cog, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port nres, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port cfg, input, 8 bits: the clkset configuration from the digital core. Bit 7 is reboot, bit 6 PLL enable, bit 5 oscillator enable, bits 4:3 oscillator mode, bits 2:0 clock select.
REQ-007 SHALL have port dig_nres, output, 1 bit: active-low reset that drives the digital core's nres.
REQ-008 SHALL have port cfg_out, output, 8 bits: the sequenced configuration passed to the clock generator; bit 7 is always 0.
REQ-009 SHALL have port state, output, 2 bits: the current FSM state (POR=0, RUN=1, REBOOT=2, SETTLE=3).
REQ-010 SHALL have port busy, output, 1 bit: 1 whenever state is not RUN.

Function
REQ-011 SHALL register cfg into cfg_q every cycle; all decisions use cfg_q, never raw cfg.
REQ-012 SHALL keep a 16-bit down-counter cnt and a register r7 holding the previous cfg_q[7].
REQ-013 SHALL drive dig_nres from a register: 0 in POR and REBOOT, 1 in RUN and SETTLE.
REQ-014 POR: cnt decrements each cycle; when cnt==0, go to RUN and set dig_nres to 1 on the same edge.
REQ-015 POR: cfg_q SHALL be ignored; cfg_out SHALL hold 0.
REQ-016 RUN, reboot: when cfg_q[7]==1 and r7==0, go to REBOOT, load cnt=REBOOT_CYCLES-1, clear dig_nres and clear cfg_out to 0 on the same edge.
REQ-017 RUN, enable change: otherwise, if cfg_q[6:3] != cfg_out[6:3], load cfg_out[6:3]=cfg_q[6:3].
REQ-018 If that change sets cfg_q[6] or cfg_q[5] from 0 to 1, go to SETTLE with cnt=SETTLE_CYCLES-1, and keep cfg_out[2:0] unchanged.
REQ-019 If the enable change turns nothing on, load cfg_out[2:0]=cfg_q[2:0] on the same edge.
REQ-020 RUN, no enable change: cfg_out[2:0] SHALL follow cfg_q[2:0], giving a latency from cfg to cfg_out of 2 edges.
REQ-021 SETTLE: cnt decrements each cycle; at cnt==0, load cfg_out[2:0] from the current cfg_q[2:0] and return to RUN.
REQ-022 SETTLE: changes to cfg_q[6:3] SHALL update cfg_out[6:3] but SHALL NOT restart cnt.
REQ-023 A reboot edge SHALL take priority over any enable change or settle activity, in both RUN and SETTLE.
REQ-024 REBOOT: cnt decrements each cycle; at cnt==0, go to RUN with dig_nres=1. cfg_q SHALL be ignored, and r7 SHALL keep tracking cfg_q[7].
REQ-025 r7 SHALL update every cycle in all states, so a cfg[7] held high across a reboot SHALL NOT trigger a second reboot.
REQ-026 cnt SHALL never wrap: it is only decremented when non-zero. A parameter value of 0 SHALL behave as 1.

Reset
REQ-027 While nres=0, all registers SHALL be asynchronously forced: state=POR, cnt=POR_CYCLES-1, dig_nres=0, cfg_q=0, r7=0, cfg_out=0, busy=1.
REQ-028 When nres is asserted mid-operation (in RUN, SETTLE or REBOOT), the block SHALL abort immediately and restart the full POR sequence after release.
REQ-029 Deassertion of nres SHALL take effect only at a clk_cog edge; no glitch on dig_nres is permitted.

Verification (POR_CYCLES=8, REBOOT_CYCLES=4, SETTLE_CYCLES=6)
REQ-030 POR: release nres -> dig_nres rises on the 8th clk_cog edge after release; state goes 0 -> 1; busy goes 1 -> 0.
REQ-031 Clock select only: in RUN, cfg 00h -> 01h -> cfg_out=01h 2 edges later; no SETTLE is entered.
REQ-032 PLL enable with select: in RUN, cfg 00h -> 6Fh ->
- cfg_out=68h after 2 edges;
- state=3 for 6 cycles;
- then cfg_out=6Fh and state=1.
REQ-033 Reboot during SETTLE: same stimulus as REQ-032, then cfg=EFh 2 cycles into SETTLE ->
- state=2, dig_nres=0, cfg_out=00h;
- dig_nres=1 after 4 cycles.
REQ-034 Held reboot bit: cfg held at 80h through a reboot and after -> exactly one reboot pulse.
REQ-035 Reset mid-reboot: nres pulsed low during REBOOT -> state=0, cfg_out=00h, dig_nres=0; full 8-cycle POR before release.

Source files
------------

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - reset and clock-configuration sequencer for the digital core
//
// Purpose: holds the digital core in reset after power-on and on a software
// reboot. It also sequences clock configuration changes so that a new clock
// select is applied only after a newly enabled oscillator or PLL has settled.
//
// Ports:
//   clk_cog   in   1  single clock, all state on its rising edge
//   nres      in   1  asynchronous active-low reset
//   cfg       in   8  clkset from core: [7] reboot, [6] PLL en, [5] osc en,
//                     [4:3] osc mode, [2:0] clock select
//   dig_nres  out  1  registered active-low reset to the digital core
//   cfg_out   out  8  sequenced configuration to the clock generator ([7]=0)
//   state     out  2  FSM state: POR=0, RUN=1, REBOOT=2, SETTLE=3
//   busy      out  1  high whenever state is not RUN
module rst_seq #(
    parameter logic [15:0] POR_CYCLES    = 16'd50000,
    parameter logic [15:0] REBOOT_CYCLES = 16'd16,
    parameter logic [15:0] SETTLE_CYCLES = 16'd1024
) (
    input  logic       clk_cog,
    input  logic       nres,
    input  logic [7:0] cfg,
    output logic       dig_nres,
    output logic [7:0] cfg_out,
    output logic [1:0] state,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_POR    = 2'd0,
        ST_RUN    = 2'd1,
        ST_REBOOT = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    // A zero-cycle request is treated as a one-cycle hold.
    localparam logic [15:0] POR_LOAD    = (POR_CYCLES    == 16'd0) ? 16'd0 : POR_CYCLES    - 16'd1;
    localparam logic [15:0] REBOOT_LOAD = (REBOOT_CYCLES == 16'd0) ? 16'd0 : REBOOT_CYCLES - 16'd1;
    localparam logic [15:0] SETTLE_LOAD = (SETTLE_CYCLES == 16'd0) ? 16'd0 : SETTLE_CYCLES - 16'd1;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        dig_nres_q;
    logic [7:0]  cfg_q;
    logic        r7_q;
    logic [6:0]  cfg_out_q;
    logic        busy_q;

    logic reboot_edge;
    logic en_turn_on;
    logic en_change;
    logic cnt_zero;

    assign reboot_edge = cfg_q[7] & ~r7_q;
    assign en_change   = (cfg_q[6:3] != cfg_out_q[6:3]);
    // Only a 0->1 transition of an oscillator/PLL enable requires settling.
    assign en_turn_on  = (cfg_q[6] & ~cfg_out_q[6]) | (cfg_q[5] & ~cfg_out_q[5]);
    assign cnt_zero    = (cnt_q == 16'd0);

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q    <= ST_POR;
            cnt_q      <= POR_LOAD;
            dig_nres_q <= 1'b0;
            cfg_q      <= 8'h00;
            r7_q       <= 1'b0;
            cfg_out_q  <= 7'h00;
            busy_q     <= 1'b1;
        end else begin
            cfg_q <= cfg;
            // Tracked in every state so a held reboot bit fires only once.
            r7_q  <= cfg_q[7];

            case (state_q)
                ST_POR: begin
                    cfg_out_q <= 7'h00;
                    if (cnt_zero) begin
                        state_q    <= ST_RUN;
                        dig_nres_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                ST_RUN: begin
                    if (reboot_edge) begin
                        state_q    <= ST_REBOOT;
                        cnt_q      <= REBOOT_LOAD;
                        dig_nres_q <= 1'b0;
                        cfg_out_q  <= 7'h00;
                        busy_q     <= 1'b1;
                    end else if (en_change) begin
                        cfg_out_q[6:3] <= cfg_q[6:3];
                        if (en_turn_on) begin
                            // Hold the old clock select until the source settles.
                            state_q <= ST_SETTLE;
                            cnt_q   <= SETTLE_LOAD;
                            busy_q  <= 1'b1;
                        end else begin
                            cfg_out_q[2:0] <= cfg_q[2:0];
                        end
                    end else begin
                        cfg_out_q[2:0] <= cfg_q[2:0];
                    end
                end

                ST_SETTLE: begin
                    if (reboot_edge) begin
                        state_q    <= ST_REBOOT;
                        cnt_q      <= REBOOT_LOAD;
                        dig_nres_q <= 1'b0;
                        cfg_out_q  <= 7'h00;
                        busy_q     <= 1'b1;
                    end else begin
                        // Enable updates pass through but do not restart the wait.
                        cfg_out_q[6:3] <= cfg_q[6:3];
                        if (cnt_zero) begin
                            cfg_out_q[2:0] <= cfg_q[2:0];
                            state_q        <= ST_RUN;
                            busy_q         <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                end

                ST_REBOOT: begin
                    cfg_out_q <= 7'h00;
                    if (cnt_zero) begin
                        state_q    <= ST_RUN;
                        dig_nres_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                default: begin
                    state_q    <= ST_POR;
                    cnt_q      <= POR_LOAD;
                    dig_nres_q <= 1'b0;
                    cfg_out_q  <= 7'h00;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign dig_nres = dig_nres_q;
    assign cfg_out  = {1'b0, cfg_out_q};
    assign state    = state_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - self-checking bench for rst_seq with behavioural model
module tb_rst_seq;

    localparam int P_POR    = 8;
    localparam int P_REBOOT = 4;
    localparam int P_SETTLE = 6;

    localparam int M_POR    = 0;
    localparam int M_RUN    = 1;
    localparam int M_REBOOT = 2;
    localparam int M_SETTLE = 3;

    logic       clk_cog;
    logic       nres;
    logic [7:0] cfg;
    logic       dig_nres;
    logic [7:0] cfg_out;
    logic [1:0] state;
    logic       busy;

    int checks;
    int failures;

    // Behavioural model: mode, cycles still to spend in a timed mode,
    // one-cycle input pipeline, previous reboot bit, and driven configuration.
    int         m_mode;
    int         m_left;
    logic [7:0] m_cfgq;
    logic       m_r7;
    logic [7:0] m_out;

    rst_seq #(
        .POR_CYCLES   (16'(P_POR)),
        .REBOOT_CYCLES(16'(P_REBOOT)),
        .SETTLE_CYCLES(16'(P_SETTLE))
    ) dut (
        .clk_cog (clk_cog),
        .nres    (nres),
        .cfg     (cfg),
        .dig_nres(dig_nres),
        .cfg_out (cfg_out),
        .state   (state),
        .busy    (busy)
    );

    initial clk_cog = 1'b0;
    always #5 clk_cog = ~clk_cog;

    function automatic int at_least_1(int p);
        return (p < 1) ? 1 : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_POR;
        m_left = at_least_1(P_POR);
        m_cfgq = 8'h00;
        m_r7   = 1'b0;
        m_out  = 8'h00;
    endtask

    // One clock edge of the spec's rules, evaluated on pre-edge values.
    task automatic model_step();
        logic       rb;
        logic       turn_on;
        logic [7:0] q;
        q       = m_cfgq;
        rb      = q[7] && !m_r7;
        turn_on = (q[6] && !m_out[6]) || (q[5] && !m_out[5]);
        case (m_mode)
            M_POR, M_REBOOT: begin
                m_out = 8'h00;
                if (m_left == 1) m_mode = M_RUN;
                else m_left--;
            end
            M_RUN: begin
                if (rb) begin
                    m_mode = M_REBOOT; m_left = at_least_1(P_REBOOT); m_out = 8'h00;
                end else begin
                    m_out[6:3] = q[6:3];
                    if (turn_on) begin
                        m_mode = M_SETTLE; m_left = at_least_1(P_SETTLE);
                    end else begin
                        m_out[2:0] = q[2:0];
                    end
                end
            end
            default: begin
                if (rb) begin
                    m_mode = M_REBOOT; m_left = at_least_1(P_REBOOT); m_out = 8'h00;
                end else begin
                    m_out[6:3] = q[6:3];
                    if (m_left == 1) begin
                        m_out[2:0] = q[2:0];
                        m_mode     = M_RUN;
                    end else begin
                        m_left--;
                    end
                end
            end
        endcase
        m_r7   = q[7];
        m_cfgq = cfg;
    endtask

    task automatic compare_model();
        chk("model_state", 32'(state), 32'(m_mode));
        chk("model_dig_nres", 32'(dig_nres), 32'(m_mode == M_RUN || m_mode == M_SETTLE));
        chk("model_cfg_out", 32'(cfg_out), 32'(m_out));
        chk("model_busy", 32'(busy), 32'(m_mode != M_RUN));
    endtask

    // Advance one edge; inputs are changed by the caller only at the negedge.
    task automatic tick();
        @(posedge clk_cog);
        if (!nres) model_reset();
        else model_step();
        @(negedge clk_cog);
        compare_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (state !== 2'd1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(state), 32'd1);
    endtask

    initial begin
        int n;
        int pulses;
        logic [1:0] prev_state;

        checks   = 0;
        failures = 0;
        nres     = 1'b0;
        cfg      = 8'h00;
        model_reset();

        // Reset values
        ticks(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_dig_nres", 32'(dig_nres), 32'd0);
        chk("rst_cfg_out", 32'(cfg_out), 32'h00);
        chk("rst_busy", 32'(busy), 32'd1);

        // Power-on sequence: dig_nres rises on the 8th edge after release
        nres = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("por_dig_nres", 32'(dig_nres), 32'(i == 8));
        end
        chk("por_state", 32'(state), 32'd1);
        chk("por_busy", 32'(busy), 32'd0);

        // Clock select only: two-edge latency, no settling
        cfg = 8'h01;
        tick();
        chk("sel_lat1", 32'(cfg_out), 32'h00);
        tick();
        chk("sel_lat2", 32'(cfg_out), 32'h01);
        chk("sel_state", 32'(state), 32'd1);
        cfg = 8'h00;
        ticks(2);
        chk("sel_back", 32'(cfg_out), 32'h00);

        // PLL enable with select
        cfg = 8'h6F;
        ticks(2);
        chk("pll_cfg_out", 32'(cfg_out), 32'h68);
        chk("pll_state", 32'(state), 32'd3);
        n = 1;
        for (int i = 0; i < 20 && state === 2'd3; i++) begin
            tick();
            if (state === 2'd3) n++;
        end
        chk("pll_settle_len", 32'(n), 32'd6);
        chk("pll_state_end", 32'(state), 32'd1);
        chk("pll_cfg_final", 32'(cfg_out), 32'h6F);

        // Reboot two cycles into SETTLE
        cfg = 8'h00;
        ticks(3);
        chk("off_cfg_out", 32'(cfg_out), 32'h00);
        cfg = 8'h6F;
        ticks(2);
        chk("rbs_settle", 32'(state), 32'd3);
        ticks(2);
        cfg = 8'hEF;
        ticks(2);
        chk("rbs_state", 32'(state), 32'd2);
        chk("rbs_dig_nres", 32'(dig_nres), 32'd0);
        chk("rbs_cfg_out", 32'(cfg_out), 32'h00);
        n = 0;
        while (dig_nres !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("rbs_hold_len", 32'(n), 32'd4);
        wait_run("rbs_run");

        // Held reboot bit produces exactly one reboot
        cfg = 8'h00;
        ticks(3);
        cfg        = 8'h80;
        pulses     = 0;
        prev_state = state;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (state === 2'd2 && prev_state !== 2'd2) pulses++;
            prev_state = state;
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_state", 32'(state), 32'd1);

        // Reset asserted mid-reboot
        cfg = 8'h00;
        ticks(3);
        cfg = 8'h80;
        n   = 0;
        while (state !== 2'd2 && n < 10) begin
            tick();
            n++;
        end
        chk("mid_in_reboot", 32'(state), 32'd2);
        #2;
        nres = 1'b0;
        #1;
        model_reset();
        chk("mid_state", 32'(state), 32'd0);
        chk("mid_cfg_out", 32'(cfg_out), 32'h00);
        chk("mid_dig_nres", 32'(dig_nres), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        @(negedge clk_cog);
        ticks(2);
        nres = 1'b1;
        n    = 0;
        while (dig_nres !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_por_len", 32'(n), 32'd8);

        // Randomized operation against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg[6:0] = 7'($urandom);
                if ($urandom_range(0, 1) == 0) cfg[6:5] = 2'b00;
            end
            if ($urandom_range(0, 19) == 0) cfg[7] = ~cfg[7];
            if ($urandom_range(0, 199) == 0) begin
                nres = 1'b0;
                #1;
                model_reset();
                compare_model();
                tick();
                nres = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
